register_file: RTL and testbench

//   Integer register file of the RISC-V core, built from N-bit single_register storage

---
 rtl/register_file_if.sv | 32 +++
 rtl/register_file.sv | 100 ++++++++++
 tb/tb_register_file.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file access bundle: two read ports with hazard flags, one writeback
// port and one issue-time reservation port.
//   master : decode/writeback side (drives addresses, write and reserve strobes)
//   slave  : register file (returns read data and pending flags)
interface register_file_if #(
    parameter int N     = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [N-1:0]  rs1_data;
    logic [N-1:0]  rs2_data;
    logic          rs1_pending;
    logic          rs2_pending;
    logic          write_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          reserve_en;
    logic [AW-1:0] reserve_addr;

    modport master (
        output rs1_addr, rs2_addr, write_en, rd_addr, rd_data, reserve_en, reserve_addr,
        input  rs1_data, rs2_data, rs1_pending, rs2_pending
    );

    modport slave (
        input  rs1_addr, rs2_addr, write_en, rd_addr, rd_data, reserve_en, reserve_addr,
        output rs1_data, rs2_data, rs1_pending, rs2_pending
    );
endinterface

// File: rtl/register_file.sv
// Integer register file: NREGS x N-bit registers, two combinational read ports
// with write-through bypass, one synchronous writeback port and a per-register
// pending scoreboard used by the stall logic.
// Ports:
//   clk   : clock, rising edge active
//   reset : asynchronous reset, active-low; clears data, pending and outputs
//   rf    : register_file_if slave (read ports, writeback, reserve)

// One architectural register plus its pending bit.
module single_register #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [N-1:0] wr_data_i,
    input  logic         rsv_i,
    output logic [N-1:0] data_o,
    output logic         pend_o
);
    logic [N-1:0] data_q;
    logic         pend_q, pend_d;

    // A reserve in the same cycle as the retiring write wins: a new writer owns the register.
    always_comb begin
        pend_d = pend_q;
        if (rsv_i)        pend_d = 1'b1;
        else if (wr_en_i) pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else begin
            if (wr_en_i) data_q <= wr_data_i;
            pend_q <= pend_d;
        end
    end

    assign data_o = data_q;
    assign pend_o = pend_q;
endmodule

module register_file #(
    parameter int N     = 64,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          reset,
    register_file_if.slave rf
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][N-1:0] regs;
    logic [NREGS-1:0]        pend;

    // x0 is hardwired: no storage, never pending.
    assign regs[0] = '0;
    assign pend[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic wr_hit, rsv_hit;
        assign wr_hit  = rf.write_en   && (rf.rd_addr      == AW'(r));
        assign rsv_hit = rf.reserve_en && (rf.reserve_addr == AW'(r));

        single_register #(.N(N)) u_reg (
            .clk       (clk),
            .rst_n     (reset),
            .wr_en_i   (wr_hit),
            .wr_data_i (rf.rd_data),
            .rsv_i     (rsv_hit),
            .data_o    (regs[r]),
            .pend_o    (pend[r])
        );
    end

    // Addresses beyond NREGS (only possible at non-power-of-two sizes) read as 0.
    logic rs1_ok, rs2_ok, rs1_byp, rs2_byp;
    assign rs1_ok  = reset && (rf.rs1_addr != '0) && (int'(rf.rs1_addr) < NREGS);
    assign rs2_ok  = reset && (rf.rs2_addr != '0) && (int'(rf.rs2_addr) < NREGS);
    // A writer retiring this cycle is forwarded and no longer counts as a hazard.
    assign rs1_byp = rf.write_en && (rf.rd_addr == rf.rs1_addr);
    assign rs2_byp = rf.write_en && (rf.rd_addr == rf.rs2_addr);

    always_comb begin
        rf.rs1_data    = '0;
        rf.rs2_data    = '0;
        rf.rs1_pending = 1'b0;
        rf.rs2_pending = 1'b0;
        if (rs1_ok) begin
            rf.rs1_data    = rs1_byp ? rf.rd_data : regs[rf.rs1_addr];
            rf.rs1_pending = pend[rf.rs1_addr] && !rs1_byp;
        end
        if (rs2_ok) begin
            rf.rs2_data    = rs2_byp ? rf.rd_data : regs[rf.rs2_addr];
            rf.rs2_pending = pend[rf.rs2_addr] && !rs2_byp;
        end
    end
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 1'b0;

    always #5 clk = ~clk;

    register_file_if #(.N(64), .NREGS(32)) rfi ();

    register_file #(.N(64), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rfi.slave)
    );

    // Architectural model: array of register values and a set of pending registers.
    logic [63:0] mregs [32];
    bit          mpend [32];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] <= 64'h0;
                mpend[i] <= 1'b0;
            end
        end else begin
            if (rfi.write_en && rfi.rd_addr != 0) begin
                mregs[rfi.rd_addr] <= rfi.rd_data;
                mpend[rfi.rd_addr] <= 1'b0;
            end
            // later assignment wins: reserve overrides a same-cycle clear
            if (rfi.reserve_en && rfi.reserve_addr != 0)
                mpend[rfi.reserve_addr] <= 1'b1;
        end
    end

    function automatic logic [63:0] exp_data(input logic [4:0] a);
        if (!reset || a == 0) return 64'h0;
        if (rfi.write_en && rfi.rd_addr == a) return rfi.rd_data;
        return mregs[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a);
        if (!reset || a == 0) return 1'b0;
        return mpend[a] && !(rfi.write_en && rfi.rd_addr == a);
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_rs1_data", rfi.rs1_data, exp_data(rfi.rs1_addr));
            check("cmp_rs2_data", rfi.rs2_data, exp_data(rfi.rs2_addr));
            check("cmp_rs1_pend", {63'h0, rfi.rs1_pending}, {63'h0, exp_pend(rfi.rs1_addr)});
            check("cmp_rs2_pend", {63'h0, rfi.rs2_pending}, {63'h0, exp_pend(rfi.rs2_addr)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rfi.write_en   = 1'b0;
        rfi.reserve_en = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        rfi.rs1_addr     = '0;
        rfi.rs2_addr     = '0;
        rfi.write_en     = 1'b0;
        rfi.rd_addr      = '0;
        rfi.rd_data      = '0;
        rfi.reserve_en   = 1'b0;
        rfi.reserve_addr = '0;

        // Reset state, with a write strobe that must be ignored.
        #2;
        rfi.rs1_addr = 5'd3; rfi.rs2_addr = 5'd3;
        rfi.write_en = 1'b1; rfi.rd_addr = 5'd3; rfi.rd_data = 64'h1234;
        #1;
        check("rst_rs1_data", rfi.rs1_data, 64'h0);
        check("rst_rs1_pend", {63'h0, rfi.rs1_pending}, 64'h0);
        @(posedge clk); #1;
        rfi.write_en = 1'b0;
        #1;
        check("rst_no_write", rfi.rs1_data, 64'h0);
        #1;
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Write x5 with same-cycle bypass on both ports.
        step();
        rfi.write_en = 1'b1; rfi.rd_addr = 5'd5; rfi.rd_data = 64'hDEAD_BEEF_0123_4567;
        rfi.rs1_addr = 5'd5; rfi.rs2_addr = 5'd5;
        #2;
        check("x5_byp_rs1", rfi.rs1_data, 64'hDEAD_BEEF_0123_4567);
        check("x5_byp_rs2", rfi.rs2_data, 64'hDEAD_BEEF_0123_4567);
        step(); idle();
        #2;
        check("x5_rd_rs1", rfi.rs1_data, 64'hDEAD_BEEF_0123_4567);
        check("x5_rd_rs2", rfi.rs2_data, 64'hDEAD_BEEF_0123_4567);

        // x0 discards writes and reserves.
        step();
        rfi.write_en = 1'b1; rfi.rd_addr = 5'd0; rfi.rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rfi.reserve_en = 1'b1; rfi.reserve_addr = 5'd0;
        rfi.rs1_addr = 5'd0;
        #2;
        check("x0_byp_data", rfi.rs1_data, 64'h0);
        step(); idle();
        #2;
        check("x0_data", rfi.rs1_data, 64'h0);
        check("x0_pend", {63'h0, rfi.rs1_pending}, 64'h0);

        // Reserve x7, then retire it.
        step();
        rfi.reserve_en = 1'b1; rfi.reserve_addr = 5'd7; rfi.rs2_addr = 5'd7;
        #2;
        check("x7_rsv_same_cyc", {63'h0, rfi.rs2_pending}, 64'h0);
        step(); idle();
        #2;
        check("x7_pend", {63'h0, rfi.rs2_pending}, 64'h1);
        step();
        rfi.write_en = 1'b1; rfi.rd_addr = 5'd7; rfi.rd_data = 64'h2A;
        #2;
        check("x7_wb_pend", {63'h0, rfi.rs2_pending}, 64'h0);
        check("x7_wb_data", rfi.rs2_data, 64'h2A);
        step(); idle();
        #2;
        check("x7_after_pend", {63'h0, rfi.rs2_pending}, 64'h0);

        // Reserve and write x9 in the same cycle: reserve wins.
        step();
        rfi.reserve_en = 1'b1; rfi.reserve_addr = 5'd9;
        rfi.write_en = 1'b1; rfi.rd_addr = 5'd9; rfi.rd_data = 64'h11;
        rfi.rs1_addr = 5'd9;
        step(); idle();
        #2;
        check("x9_data", rfi.rs1_data, 64'h11);
        check("x9_pend", {63'h0, rfi.rs1_pending}, 64'h1);

        // Reserve an already-pending register, and write a non-pending one.
        step();
        rfi.reserve_en = 1'b1; rfi.reserve_addr = 5'd9;
        rfi.write_en = 1'b1; rfi.rd_addr = 5'd4; rfi.rd_data = 64'h8000_0000_0000_0001;
        rfi.rs2_addr = 5'd4;
        step(); idle();
        #2;
        check("x9_still_pend", {63'h0, rfi.rs1_pending}, 64'h1);
        check("x4_data", rfi.rs2_data, 64'h8000_0000_0000_0001);
        check("x4_pend", {63'h0, rfi.rs2_pending}, 64'h0);

        // Back-to-back writes x1..x31 = addr*3, then sweep both ports.
        for (int a = 1; a < 32; a++) begin
            step();
            rfi.write_en = 1'b1; rfi.rd_addr = 5'(a); rfi.rd_data = 64'(a * 3);
            rfi.rs1_addr = 5'(a); rfi.rs2_addr = 5'(a - 1);
        end
        step(); idle();
        for (int a = 0; a < 32; a++) begin
            rfi.rs1_addr = 5'(a); rfi.rs2_addr = 5'(31 - a);
            #2;
            check("sweep_rs1_data", rfi.rs1_data, 64'(a * 3));
            check("sweep_rs2_data", rfi.rs2_data, 64'((31 - a) * 3));
            check("sweep_rs1_pend", {63'h0, rfi.rs1_pending}, 64'h0);
            step();
        end

        // Mid-cycle asynchronous reset with loaded, pending registers.
        rfi.reserve_en = 1'b1; rfi.reserve_addr = 5'd12;
        step(); idle();
        rfi.rs1_addr = 5'd12; rfi.rs2_addr = 5'd31;
        #1;
        check("pre_rst_pend", {63'h0, rfi.rs1_pending}, 64'h1);
        check("pre_rst_data", rfi.rs2_data, 64'd93);
        reset = 1'b0;
        #1;
        check("async_rst_rs1_data", rfi.rs1_data, 64'h0);
        check("async_rst_rs2_data", rfi.rs2_data, 64'h0);
        check("async_rst_rs1_pend", {63'h0, rfi.rs1_pending}, 64'h0);
        step();
        #1;
        reset = 1'b1;
        #1;
        check("post_rst_x12_data", rfi.rs1_data, 64'h0);
        check("post_rst_x12_pend", {63'h0, rfi.rs1_pending}, 64'h0);
        check("post_rst_x31_data", rfi.rs2_data, 64'h0);
        step();
        step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
